program_loader: RTL

Upstream feeder for `program_memory`: accepts a program as a stream of 32-bit instruction words over a valid/ready handshake and packs them into the 256-bit `program_address_array` bus (slot 0 in bits 31:0 through slot 7 in bits 255:224). A zero word terminates the program early. The bus is presented stable under `program_valid` until the consumer acknowledges it. The block then clears itself for the next program.

---
 rtl/program_loader.sv | 102 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: packs a stream of 32-bit instruction words into the
// 256-bit program bus consumed by program_memory. A zero word ends the
// program early; the bus is held under program_valid until acknowledged.
//
// state | meaning
// FILL  | accepting words into the next free slot
// HOLD  | program complete, bus frozen until program_ack or abort
module program_loader #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WORD_W-1:0]         word_in,
    input  logic                      word_valid,
    output logic                      word_ready,
    input  logic                      abort,
    output logic [WORD_W*DEPTH-1:0]   program_address_array,
    output logic                      program_valid,
    input  logic                      program_ack,
    output logic [3:0]                word_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [WORD_W*DEPTH-1:0]  array_q, array_d;
    logic [3:0]               count_q, count_d;

    // Handshake flags come straight from the state register.
    assign word_ready            = (state_q == FILL);
    assign program_valid         = (state_q == HOLD);
    assign program_address_array = array_q;
    assign word_count            = count_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= 3'd0;
            array_q <= '0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            array_q <= array_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: abort beats both an accept and an acknowledge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        array_d = array_q;
        count_d = count_q;

        if (abort) begin
            state_d = FILL;
            idx_d   = 3'd0;
            array_d = '0;
            count_d = 4'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (word_valid) begin
                        if (word_in != '0) begin
                            array_d[{idx_q, 5'd0} +: 32] = word_in;
                            count_d = count_q + 4'd1;
                            // The last slot forces HOLD, so the index is
                            // parked rather than wrapped.
                            if (idx_q == 3'd7) begin
                                state_d = HOLD;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end else begin
                            // Terminator: remaining slots are already zero.
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (program_ack) begin
                        state_d = FILL;
                        idx_d   = 3'd0;
                        array_d = '0;
                        count_d = 4'd0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

endmodule
